// File: rtl/fpu_pkg.sv
// Shared FPU types: opcode and sequencer state encodings,
// plus the per-op latency lookup used when a request is accepted.
package fpu_pkg;

   typedef enum logic [2:0] {
      FADD = 3'd0,
      FSUB = 3'd1,
      FMUL = 3'd2,
      FDIV = 3'd3,
      FEQ  = 3'd4,
      FLT  = 3'd5,
      FLE  = 3'd6,
      FRSV = 3'd7
   } fpu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } fpu_state_t;

   function automatic int lat_of(
      input fpu_op_t op,
      input int      la,
      input int      lm,
      input int      ld
   );
      case (op)
         FADD, FSUB: return la;
         FMUL:       return lm;
         FDIV:       return ld;
         default:    return 1;
      endcase
   endfunction

endpackage

// File: rtl/fadd.sv
// Combinational single-precision adder, truncating, normals only.
// Zero-exponent operands are treated as zero.
module fadd (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y,
   output logic        ovf
);

   logic [31:0] x;
   logic [31:0] z;
   logic [7:0]  d;
   logic [24:0] mx;
   logic [24:0] mz;
   logic [24:0] s;
   logic [4:0]  lz;
   int          e;

   always_comb begin
      if (a[30:0] >= b[30:0]) begin
         x = a;
         z = b;
      end else begin
         x = b;
         z = a;
      end
      d   = x[30:23] - z[30:23];
      mx  = {2'b01, x[22:0]};
      mz  = {2'b01, z[22:0]} >> d;
      e   = int'(x[30:23]);
      lz  = '0;
      s   = '0;
      y   = x;
      ovf = 1'b0;
      if (z[30:23] != 8'd0) begin
         if (x[31] == z[31]) begin
            s = mx + mz;
            if (s[24]) begin
               s = s >> 1;
               e = e + 1;
            end
         end else begin
            s  = mx - mz;
            lz = 5'd24;
            for (int i = 0; i < 24; i++)
               if (s[i]) lz = 5'(23 - i);
            s = s << lz;
            e = e - int'(lz);
         end
         if (s == '0)
            y = '0;
         else if (e >= 255) begin
            ovf = 1'b1;
            y   = {x[31], 8'hFF, 23'd0};
         end else if (e <= 0)
            y = {x[31], 31'd0};
         else
            y = {x[31], e[7:0], s[22:0]};
      end
   end

endmodule

// File: rtl/fdiv.sv
// Combinational single-precision divider, truncating.
// Divide by zero returns signed infinity and raises ovf.
module fdiv (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y,
   output logic        ovf
);

   logic [47:0] q;
   logic [22:0] m;
   logic        sg;
   int          e;

   always_comb begin
      sg  = a[31] ^ b[31];
      q   = {1'b1, a[22:0], 24'd0} / {24'd0, 1'b1, b[22:0]};
      e   = int'(a[30:23]) - int'(b[30:23]) + 127;
      m   = 23'(q >> 1);
      y   = {sg, 31'd0};
      ovf = 1'b0;
      if (!q[24]) begin
         m = 23'(q);
         e = e - 1;
      end
      if (b[30:23] == 8'd0) begin
         ovf = 1'b1;
         y   = {sg, 8'hFF, 23'd0};
      end else if (a[30:23] != 8'd0) begin
         if (e >= 255) begin
            ovf = 1'b1;
            y   = {sg, 8'hFF, 23'd0};
         end else if (e > 0)
            y = {sg, e[7:0], m};
      end
   end

endmodule

// File: rtl/fmul.sv
// Combinational single-precision multiplier, truncating.
// Zero-exponent operands give a signed zero.
module fmul (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y,
   output logic        ovf
);

   logic [47:0] p;
   logic [22:0] m;
   logic        sg;
   int          e;

   always_comb begin
      sg  = a[31] ^ b[31];
      p   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e   = int'(a[30:23]) + int'(b[30:23]) - 127;
      m   = 23'(p >> 23);
      y   = {sg, 31'd0};
      ovf = 1'b0;
      if (p[47]) begin
         m = 23'(p >> 24);
         e = e + 1;
      end
      if (a[30:23] != 8'd0 && b[30:23] != 8'd0) begin
         if (e >= 255) begin
            ovf = 1'b1;
            y   = {sg, 8'hFF, 23'd0};
         end else if (e > 0)
            y = {sg, e[7:0], m};
      end
   end

endmodule

// File: rtl/fpu_cmp.sv
// Sign-magnitude float compare; +0 and -0 are equal,
// everything else compares as its encoded bit pattern.
module fpu_cmp (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        feq,
   output logic        flt,
   output logic        fle
);

   logic both_zero;

   assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
   assign feq       = (a == b) || both_zero;

   always_comb begin
      if (both_zero)
         flt = 1'b0;
      else if (a[31] != b[31])
         flt = a[31];
      else if (a[31])
         flt = a[30:0] > b[30:0];
      else
         flt = a[30:0] < b[30:0];
   end

   assign fle = flt | feq;

endmodule

// File: rtl/fsub.sv
// Combinational single-precision subtract: add with
// the second operand's sign flipped.
module fsub (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y,
   output logic        ovf
);

   fadd u_add (
      .a   (a),
      .b   ({~b[31], b[30:0]}),
      .y   (y),
      .ovf (ovf)
   );

endmodule

// File: rtl/fpu_seq.sv
// Handshaked multi-cycle FPU sequencer: latches operands, waits
// a per-op cycle count for the combinational units, then returns.
module fpu_seq
   import fpu_pkg::*;
#(
   parameter int LAT_ADD = 2,
   parameter int LAT_MUL = 2,
   parameter int LAT_DIV = 8,
   parameter int TAG_W   = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [31:0]      src1,
   input  logic [31:0]      src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      result,
   output logic             ovf,
   output logic [TAG_W-1:0] out_tag
);

   fpu_state_t       state_q, state_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [31:0]      a_q, a_d, b_q, b_d;
   fpu_op_t          op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d, out_tag_d;
   logic [31:0]      result_d, res_c;
   logic             ovf_d, ovf_c;
   logic [31:0]      add_y, sub_y, mul_y, div_y;
   logic             add_o, sub_o, mul_o, div_o;
   logic             feq, flt, fle;

   fadd u_fadd (.a(a_q), .b(b_q), .y(add_y), .ovf(add_o));
   fsub u_fsub (.a(a_q), .b(b_q), .y(sub_y), .ovf(sub_o));
   fmul u_fmul (.a(a_q), .b(b_q), .y(mul_y), .ovf(mul_o));
   fdiv u_fdiv (.a(a_q), .b(b_q), .y(div_y), .ovf(div_o));

   fpu_cmp u_cmp (
      .a   (a_q),
      .b   (b_q),
      .feq (feq),
      .flt (flt),
      .fle (fle)
   );

   always_comb begin
      res_c = '0;
      ovf_c = 1'b0;
      case (op_q)
         FADD: begin res_c = add_y; ovf_c = add_o; end
         FSUB: begin res_c = sub_y; ovf_c = sub_o; end
         FMUL: begin res_c = mul_y; ovf_c = mul_o; end
         FDIV: begin res_c = div_y; ovf_c = div_o; end
         FEQ:  res_c = {31'd0, feq};
         FLT:  res_c = {31'd0, flt};
         FLE:  res_c = {31'd0, fle};
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      tag_d     = tag_q;
      result_d  = result;
      ovf_d     = ovf;
      out_tag_d = out_tag;
      unique case (state_q)
         IDLE: if (in_valid) begin
            a_d     = src1;
            b_d     = src2;
            op_d    = fpu_op_t'(in_op);
            tag_d   = in_tag;
            cnt_d   = 16'(lat_of(fpu_op_t'(in_op),
                         LAT_ADD, LAT_MUL, LAT_DIV) - 1);
            state_d = BUSY;
         end
         BUSY: if (cnt_q == '0) begin
            result_d  = res_c;
            ovf_d     = ovf_c;
            out_tag_d = tag_q;
            state_d   = DONE;
         end else
            cnt_d = cnt_q - 16'd1;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= FADD;
         tag_q   <= '0;
         result  <= '0;
         ovf     <= 1'b0;
         out_tag <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         tag_q   <= tag_d;
         result  <= result_d;
         ovf     <= ovf_d;
         out_tag <= out_tag_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

endmodule
